// File: rtl/instr_fetch_unit_if.sv
`timescale 1ns/1ps
// Purpose : fetch-control bundle between instr_fetch_unit and the datapath.
// Latency : n/a (wires only); master = fetch unit, slave = datapath/memory side.
// Backpressure: MFC stalls the fetch in the read phase, done releases the wait phase.
// Signals : done/MFC/pcInc into the fetch unit; PCoutEN, marIn, memEN, RW,
//           mdReadEN, mdrOut, IRin, PCout, fetch_err out of it.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              done;
    logic              MFC;
    logic              pcInc;
    logic              PCoutEN;
    logic              marIn;
    logic              memEN;
    logic              RW;
    logic              mdReadEN;
    logic              mdrOut;
    logic              IRin;
    logic [ADDR_W-1:0] PCout;
    logic              fetch_err;

    modport master (
        input  done, MFC, pcInc,
        output PCoutEN, marIn, memEN, RW, mdReadEN, mdrOut, IRin, PCout, fetch_err
    );

    modport slave (
        output done, MFC, pcInc,
        input  PCoutEN, marIn, memEN, RW, mdReadEN, mdrOut, IRin, PCout, fetch_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
// Purpose : instruction-fetch sequencer (PC -> MAR, read, MDR -> IR, PC+1) plus program counter.
// Latency : 4 clocks T0 -> WAIT when MFC is already high; Moore outputs decoded from state.
// Backpressure: holds in T1 until MFC, holds in WAIT until done.
// Ports   : clk, rst (synchronous, active low), bus (instr_fetch_unit_if.master).
// Option  : FETCH_TIMEOUT_EN builds an MFC timeout counter and sticky fetch_err;
//           without it T1 waits indefinitely and fetch_err is tied to 0.
module instr_fetch_unit #(
    parameter int              ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int              TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,   // address phase
        S_T1   = 3'd2,   // memory read, waiting for MFC
        S_T2   = 3'd3,   // latch MDR
        S_T3   = 3'd4,   // load IR, PC increments on exit
        S_WAIT = 3'd5    // execute in progress
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              to_hit;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             err_q, err_d;

    // Final MFC-less cycle in T1; MFC on the same edge takes priority in the next-state logic.
    assign to_hit = (state_q == S_T1) && !bus.MFC && (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        to_cnt_d = to_cnt_q;
        // Held at zero outside T1, so every entry into T1 starts a fresh count.
        if (state_q != S_T1) begin
            to_cnt_d = '0;
        end else if (!bus.MFC) begin
            to_cnt_d = to_cnt_q + CNT_W'(1);
        end
        err_d = err_q | to_hit;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign bus.fetch_err = err_q;
`else
    assign to_hit        = 1'b0;
    assign bus.fetch_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // A coincident pcInc and T3 increment still advance the PC by one.
    always_comb begin
        pc_d = pc_q;
        if ((state_q == S_T3) || bus.pcInc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_comb begin
        state_d = S_IDLE;
        unique case (state_q)
            S_IDLE: state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1: begin
                if (bus.MFC) begin
                    state_d = S_T2;
                end else if (to_hit) begin
                    state_d = S_T0;     // retry the fetch, PC untouched
                end else begin
                    state_d = S_T1;
                end
            end
            S_T2:   state_d = S_T3;
            S_T3:   state_d = S_WAIT;
            S_WAIT: state_d = bus.done ? S_T0 : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    logic pc_out_en, mar_in, mem_en, rw, md_read_en, mdr_out, ir_in;

    always_comb begin
        pc_out_en  = 1'b0;
        mar_in     = 1'b0;
        mem_en     = 1'b0;
        rw         = 1'b0;
        md_read_en = 1'b0;
        mdr_out    = 1'b0;
        ir_in      = 1'b0;
        case (state_q)
            S_T0: begin
                pc_out_en = 1'b1;
                mar_in    = 1'b1;
            end
            S_T1: begin
                mem_en = 1'b1;
                rw     = 1'b1;
            end
            S_T2: begin
                mem_en     = 1'b1;
                rw         = 1'b1;
                md_read_en = 1'b1;
            end
            S_T3: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.PCoutEN  = pc_out_en;
    assign bus.marIn    = mar_in;
    assign bus.memEN    = mem_en;
    assign bus.RW       = rw;
    assign bus.mdReadEN = md_read_en;
    assign bus.mdrOut   = mdr_out;
    assign bus.IRin     = ir_in;
    assign bus.PCout    = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
// Purpose : directed self-checking bench for instr_fetch_unit.
// Latency : inputs driven and outputs sampled on the falling edge of a 20 ns clock.
// Backpressure: MFC and done driven directly from the scenario tasks.
module tb_instr_fetch_unit;

    localparam logic [6:0] OUT_IDLE = 7'b0000000;
    localparam logic [6:0] OUT_T0   = 7'b1100000;
    localparam logic [6:0] OUT_T1   = 7'b0011000;
    localparam logic [6:0] OUT_T2   = 7'b0011100;
    localparam logic [6:0] OUT_T3   = 7'b0000011;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [6:0] outs;

    instr_fetch_unit_if #(.ADDR_W(16)) bus ();

    instr_fetch_unit #(
        .ADDR_W(16),
        .RESET_PC(16'h0000),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // {PCoutEN, marIn, memEN, RW, mdReadEN, mdrOut, IRin}
    assign outs = {bus.PCoutEN, bus.marIn, bus.memEN, bus.RW, bus.mdReadEN, bus.mdrOut, bus.IRin};

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.PCout !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_pc: got %h required %h", bus.PCout, 16'h0000);
        end
        tests_run++;
        if (outs !== OUT_IDLE) begin
            tests_failed++; $display("FAIL reset_outs: got %b required %b", outs, OUT_IDLE);
        end
        tests_run++;
        if (bus.fetch_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_err: got %b required 0", bus.fetch_err);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (outs !== OUT_T0 || bus.PCout !== 16'h0000) begin
            tests_failed++; $display("FAIL idle_to_t0: got outs=%b pc=%h required outs=%b pc=0000", outs, bus.PCout, OUT_T0);
        end
    endtask

    // From T0: three MFC-less cycles in T1, then MFC completes the read.
    task automatic test_fetch_mfc_wait();
        bus.MFC = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (outs !== OUT_T1) begin
                tests_failed++; $display("FAIL t1_hold[%0d]: got %b required %b", i, outs, OUT_T1);
            end
            if (i == 3) bus.MFC = 1'b1;
        end
        @(negedge clk);
        bus.MFC = 1'b0;
        tests_run++;
        if (outs !== OUT_T2) begin
            tests_failed++; $display("FAIL t2_outs: got %b required %b", outs, OUT_T2);
        end
        @(negedge clk);
        tests_run++;
        if (outs !== OUT_T3 || bus.PCout !== 16'h0000) begin
            tests_failed++; $display("FAIL t3_outs: got outs=%b pc=%h required outs=%b pc=0000", outs, bus.PCout, OUT_T3);
        end
        @(negedge clk);
        tests_run++;
        if (outs !== OUT_IDLE || bus.PCout !== 16'h0001) begin
            tests_failed++; $display("FAIL wait_after_t3: got outs=%b pc=%h required outs=%b pc=0001", outs, bus.PCout, OUT_IDLE);
        end
    endtask

    task automatic test_wait_hold();
        bus.done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (outs !== OUT_IDLE || bus.PCout !== 16'h0001) begin
                tests_failed++; $display("FAIL wait_hold[%0d]: got outs=%b pc=%h required outs=%b pc=0001", i, outs, bus.PCout, OUT_IDLE);
            end
        end
    endtask

    // pcInc in WAIT for two cycles, then done releases into T0.
    task automatic test_pc_inc_wait();
        bus.pcInc = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.PCout !== 16'h0002) begin
            tests_failed++; $display("FAIL pcinc_wait1: got %h required %h", bus.PCout, 16'h0002);
        end
        @(negedge clk);
        bus.pcInc = 1'b0;
        tests_run++;
        if (bus.PCout !== 16'h0003 || outs !== OUT_IDLE) begin
            tests_failed++; $display("FAIL pcinc_wait2: got pc=%h outs=%b required pc=0003 outs=%b", bus.PCout, outs, OUT_IDLE);
        end
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        tests_run++;
        if (outs !== OUT_T0 || bus.PCout !== 16'h0003) begin
            tests_failed++; $display("FAIL done_to_t0: got outs=%b pc=%h required outs=%b pc=0003", outs, bus.PCout, OUT_T0);
        end
    endtask

    // Minimum-latency fetch; done high outside WAIT is ignored, pcInc in T3 gives a single increment.
    task automatic test_back_to_back();
        bus.MFC  = 1'b1;
        bus.done = 1'b1;
        @(negedge clk);
        tests_run++;
        if (outs !== OUT_T1) begin
            tests_failed++; $display("FAIL min_t1: got %b required %b", outs, OUT_T1);
        end
        @(negedge clk);
        tests_run++;
        if (outs !== OUT_T2) begin
            tests_failed++; $display("FAIL min_t2: got %b required %b", outs, OUT_T2);
        end
        @(negedge clk);
        tests_run++;
        if (outs !== OUT_T3 || bus.PCout !== 16'h0003) begin
            tests_failed++; $display("FAIL min_t3: got outs=%b pc=%h required outs=%b pc=0003", outs, bus.PCout, OUT_T3);
        end
        bus.pcInc = 1'b1;
        bus.done  = 1'b0;
        bus.MFC   = 1'b0;
        @(negedge clk);
        bus.pcInc = 1'b0;
        tests_run++;
        if (outs !== OUT_IDLE || bus.PCout !== 16'h0004) begin
            tests_failed++; $display("FAIL t3_pcinc_single: got outs=%b pc=%h required outs=%b pc=0004", outs, bus.PCout, OUT_IDLE);
        end
    endtask

    task automatic test_wrap();
        bus.pcInc = 1'b1;
        repeat (16'hFFFF - 16'h0004) @(negedge clk);
        bus.pcInc = 1'b0;
        tests_run++;
        if (bus.PCout !== 16'hFFFF || outs !== OUT_IDLE) begin
            tests_failed++; $display("FAIL pc_to_ffff: got pc=%h outs=%b required pc=ffff outs=%b", bus.PCout, outs, OUT_IDLE);
        end
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        bus.MFC  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.MFC = 1'b0;
        @(negedge clk);
        tests_run++;
        if (outs !== OUT_T3 || bus.PCout !== 16'hFFFF) begin
            tests_failed++; $display("FAIL wrap_t3: got outs=%b pc=%h required outs=%b pc=ffff", outs, bus.PCout, OUT_T3);
        end
        @(negedge clk);
        tests_run++;
        if (bus.PCout !== 16'h0000 || outs !== OUT_IDLE) begin
            tests_failed++; $display("FAIL pc_wrap: got pc=%h outs=%b required pc=0000 outs=%b", bus.PCout, outs, OUT_IDLE);
        end
    endtask

    // Reset asserted in T1 with pcInc and MFC also high: reset wins.
    task automatic test_reset_mid_fetch();
        bus.pcInc = 1'b1;
        @(negedge clk);
        bus.pcInc = 1'b0;
        bus.done  = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        @(negedge clk);
        tests_run++;
        if (outs !== OUT_T1 || bus.PCout !== 16'h0001) begin
            tests_failed++; $display("FAIL pre_reset_t1: got outs=%b pc=%h required outs=%b pc=0001", outs, bus.PCout, OUT_T1);
        end
        rst       = 1'b0;
        bus.pcInc = 1'b1;
        bus.MFC   = 1'b1;
        @(negedge clk);
        tests_run++;
        if (outs !== OUT_IDLE || bus.PCout !== 16'h0000 || bus.fetch_err !== 1'b0) begin
            tests_failed++; $display("FAIL mid_reset: got outs=%b pc=%h err=%b required outs=%b pc=0000 err=0", outs, bus.PCout, bus.fetch_err, OUT_IDLE);
        end
        bus.pcInc = 1'b0;
        bus.MFC   = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        tests_run++;
        if (outs !== OUT_T0 || bus.PCout !== 16'h0000) begin
            tests_failed++; $display("FAIL post_reset_t0: got outs=%b pc=%h required outs=%b pc=0000", outs, bus.PCout, OUT_T0);
        end
    endtask

    // Starts in T0 with PC=0 and MFC held low.
    task automatic test_mfc_timeout();
        bus.MFC = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            tests_run++;
            if (outs !== OUT_T1 || bus.fetch_err !== 1'b0) begin
                tests_failed++; $display("FAIL to_t1[%0d]: got outs=%b err=%b required outs=%b err=0", i, outs, bus.fetch_err, OUT_T1);
            end
        end
        @(negedge clk);
        tests_run++;
        if (outs !== OUT_T0 || bus.fetch_err !== 1'b1 || bus.PCout !== 16'h0000) begin
            tests_failed++; $display("FAIL to_retry: got outs=%b err=%b pc=%h required outs=%b err=1 pc=0000", outs, bus.fetch_err, bus.PCout, OUT_T0);
        end
        bus.MFC = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.MFC = 1'b0;
        tests_run++;
        if (outs !== OUT_T2) begin
            tests_failed++; $display("FAIL to_t2: got %b required %b", outs, OUT_T2);
        end
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (outs !== OUT_IDLE || bus.PCout !== 16'h0001 || bus.fetch_err !== 1'b1) begin
            tests_failed++; $display("FAIL to_sticky: got outs=%b pc=%h err=%b required outs=%b pc=0001 err=1", outs, bus.PCout, bus.fetch_err, OUT_IDLE);
        end
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests_run++;
            if (outs !== OUT_T1 || bus.fetch_err !== 1'b0) begin
                tests_failed++; $display("FAIL no_to_t1[%0d]: got outs=%b err=%b required outs=%b err=0", i, outs, bus.fetch_err, OUT_T1);
            end
        end
        bus.MFC = 1'b1;
        @(negedge clk);
        bus.MFC = 1'b0;
        tests_run++;
        if (outs !== OUT_T2) begin
            tests_failed++; $display("FAIL no_to_t2: got %b required %b", outs, OUT_T2);
        end
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (outs !== OUT_IDLE || bus.PCout !== 16'h0001 || bus.fetch_err !== 1'b0) begin
            tests_failed++; $display("FAIL no_to_done: got outs=%b pc=%h err=%b required outs=%b pc=0001 err=0", outs, bus.PCout, bus.fetch_err, OUT_IDLE);
        end
`endif
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        bus.done     = 1'b0;
        bus.MFC      = 1'b0;
        bus.pcInc    = 1'b0;

        test_reset();
        test_fetch_mfc_wait();
        test_wait_hold();
        test_pc_inc_wait();
        test_back_to_back();
        test_wrap();
        test_reset_mid_fetch();
        test_mfc_timeout();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
